// File: rtl/jk_register_bank.sv
// Master-slave register bank: the master stage updates on the rising edge and the
// slave stage on the falling edge. Each bit acts as a JK or T flip-flop, or the bank
// acts as a D register or as an up/down counter.
module jk_register_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_T    = 2'b01,
        MODE_D    = 2'b10,
        MODE_CNT  = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_tc;

    logic [WIDTH-1:0] w_jkNext;
    logic [WIDTH-1:0] w_tNext;
    logic [WIDTH-1:0] w_cntNext;
    logic [WIDTH-1:0] w_mNext;
    logic             w_atMax;
    logic             w_atZero;
    logic             w_tcNext;
    mode_t            w_mode;

    assign w_mode    = mode_t'(mode);
    assign w_jkNext  = (j & ~r_m) | (~k & r_m);
    assign w_tNext   = r_m ^ j;
    assign w_cntNext = dir ? (r_m + ONE) : (r_m - ONE);
    assign w_atMax   = &r_m;
    assign w_atZero  = ~|r_m;

    always_comb begin
        w_mNext = r_m;
        if (clr) begin
            w_mNext = RESET_VAL;
        end else if (en) begin
            case (w_mode)
                MODE_JK:  w_mNext = w_jkNext;
                MODE_T:   w_mNext = w_tNext;
                MODE_D:   w_mNext = d;
                MODE_CNT: w_mNext = w_cntNext;
                default:  w_mNext = r_m;
            endcase
        end
    end

    // Terminal count is judged on the freshly updated master with the controls still driven.
    assign w_tcNext = (w_mode == MODE_CNT) & en & ~clr &
                      ((dir & w_atMax) | (~dir & w_atZero));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m <= RESET_VAL;
        end else begin
            r_m <= w_mNext;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= RESET_VAL;
            r_tc <= 1'b0;
        end else begin
            r_q  <= r_m;
            r_tc <= w_tcNext;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;
    assign tc   = r_tc;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed bench for jk_register_bank: stimulus pushes hand-computed expectations,
// a monitor pops and checks them after every falling edge.
module tb_jk_register_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic       dir;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       tc;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] expQ[$];
    logic       expTc[$];
    string      expName[$];

    jk_register_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .mode (mode),
        .j    (j),
        .k    (k),
        .d    (d),
        .dir  (dir),
        .q    (q),
        .qbar (qbar),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] wantQ, input logic wantTc);
        compared++;
        if (q !== wantQ || qbar !== ~wantQ || tc !== wantTc) begin
            mismatched++;
            $display("[TB] FAIL %s: got q=%h qbar=%h tc=%b, want q=%h qbar=%h tc=%b",
                     name, q, qbar, tc, wantQ, ~wantQ, wantTc);
        end
    endtask

    task automatic expectNext(input string name, input logic [7:0] wantQ, input logic wantTc);
        expQ.push_back(wantQ);
        expTc.push_back(wantTc);
        expName.push_back(name);
    endtask

    // Drive one cycle's inputs just after a falling edge so the next rising edge samples them.
    task automatic applyStimulus(input string name, input logic [1:0] m, input logic e,
                                 input logic c, input logic [7:0] jj, input logic [7:0] kk,
                                 input logic [7:0] dd, input logic dr,
                                 input logic [7:0] wantQ, input logic wantTc);
        @(negedge clk);
        #2;
        mode = m; en = e; clr = c; j = jj; k = kk; d = dd; dir = dr;
        expectNext(name, wantQ, wantTc);
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() > 0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending, want 0", expQ.size());
            expQ.delete();
            expTc.delete();
            expName.delete();
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expName.pop_front(), expQ.pop_front(), expTc.pop_front());
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL global_timeout: got running, want finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00;
        j = 8'h00; k = 8'h00; d = 8'h00; dir = 1'b0;
        #3;
        checkOutput("power_on_reset", 8'h00, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;

        // Load A5, then pull reset in the middle of the high phase.
        applyStimulus("load_a5", 2'b10, 1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0);
        drain();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_mid_high", 8'h00, 1'b0);
        en = 1'b0; mode = 2'b00; d = 8'h00;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("reset_en0_hold", 2'b00, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        end

        applyStimulus("jk_set_reset", 2'b00, 1'b1, 1'b0, 8'hF0, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("jk_no_change_at_posedge", 8'h00, 1'b0);
        applyStimulus("jk_toggle", 2'b00, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h0F, 1'b0);
        applyStimulus("jk_hold", 2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h0F, 1'b0);

        applyStimulus("d_load_3c", 2'b10, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0);
        applyStimulus("t_toggle_81", 2'b01, 1'b1, 1'b0, 8'h81, 8'hFF, 8'h00, 1'b0, 8'hBD, 1'b0);
        applyStimulus("t_en0_hold", 2'b01, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hBD, 1'b0);

        applyStimulus("d_load_fe", 2'b10, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFE, 1'b1, 8'hFE, 1'b0);
        applyStimulus("count_up_ff_tc", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        applyStimulus("count_up_wrap", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        applyStimulus("d_load_01", 2'b10, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0);
        applyStimulus("count_down_zero_tc", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        applyStimulus("count_down_wrap", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0);

        applyStimulus("clr_over_en0", 2'b11, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        applyStimulus("count_up_01", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        applyStimulus("count_up_02", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0);

        // Reset pulse between a counting posedge and the following negedge.
        drain();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("count_reset_pulse", 8'h00, 1'b0);
        #1;
        rst = 1'b1;
        expectNext("after_reset_release", 8'h00, 1'b0);
        applyStimulus("count_resume_01", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        applyStimulus("count_resume_02", 2'b11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
